seq_magnitude_comparator: RTL and testbench

SEQ_MAGNITUDE_COMPARATOR -- requirements
Module: seq_magnitude_comparator

---
 rtl/seq_magnitude_comparator.sv | 108 ++++++++++
 tb/tb_seq_magnitude_comparator.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator: MSB-first, DIGIT-bits-per-clock magnitude compare with optional early exit
module seq_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4,
  parameter int EARLY_EXIT = 1,
  localparam int NS = WIDTH / DIGIT,
  localparam int CW = $clog2(NS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             b_gt_a,
  output logic [CW-1:0]    cycles
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0] k_q, k_d, cycles_q, cycles_d;
  logic gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
  logic dgt_q, dgt_d, dlt_q, dlt_d;
  logic [DIGIT-1:0] sa, sb;
  logic ngt, nlt, last;
  logic [WIDTH-1:0] msb;
  assign msb = WIDTH'(signed_mode) << (WIDTH - 1);
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    k_d = k_q;
    cycles_d = cycles_q;
    gt_d = gt_q;
    eq_d = eq_q;
    lt_d = lt_q;
    dgt_d = dgt_q;
    dlt_d = dlt_q;
    sa = a_q[WIDTH-1 -: DIGIT];
    sb = b_q[WIDTH-1 -: DIGIT];
    // a decision from an earlier slice sticks; only an undecided compare looks at this slice
    ngt = dgt_q | (!dlt_q && sa > sb);
    nlt = dlt_q | (!dgt_q && sa < sb);
    last = k_q == CW'(NS - 1);
    if (state_q == RUN) begin
      a_d = a_q << DIGIT;
      b_d = b_q << DIGIT;
      k_d = k_q + 1'b1;
      dgt_d = ngt;
      dlt_d = nlt;
      if (last || (EARLY_EXIT != 0 && (ngt || nlt))) begin
        state_d = DONE;
        gt_d = ngt;
        lt_d = nlt;
        eq_d = !(ngt || nlt);
        cycles_d = k_q + 1'b1;
      end
    end else if (start) begin
      state_d = RUN;
      a_d = a ^ msb;
      b_d = b ^ msb;
      k_d = '0;
      cycles_d = '0;
      gt_d = 1'b0;
      eq_d = 1'b0;
      lt_d = 1'b0;
      dgt_d = 1'b0;
      dlt_d = 1'b0;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      k_q <= '0;
      cycles_q <= '0;
      gt_q <= 1'b0;
      eq_q <= 1'b0;
      lt_q <= 1'b0;
      dgt_q <= 1'b0;
      dlt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      k_q <= k_d;
      cycles_q <= cycles_d;
      gt_q <= gt_d;
      eq_q <= eq_d;
      lt_q <= lt_d;
      dgt_q <= dgt_d;
      dlt_q <= dlt_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign a_gt_b = gt_q;
  assign a_eq_b = eq_q;
  assign b_gt_a = lt_q;
  assign cycles = cycles_q;
endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// tb_seq_magnitude_comparator: arithmetic reference model plus directed vectors over three configurations
module tb_seq_magnitude_comparator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic smode = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [2:0] o_busy, o_done, o_gt, o_eq, o_lt;
  logic [2:0] o_cyc [3];
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;

  // 0: 16/4 early exit, 1: 16/4 constant time, 2: 4/1 early exit
  seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1)) u16 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(smode), .a(a16), .b(b16),
    .busy(o_busy[0]), .done(o_done[0]), .a_gt_b(o_gt[0]), .a_eq_b(o_eq[0]), .b_gt_a(o_lt[0]), .cycles(o_cyc[0]));
  seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(0)) u16c (
    .clk(clk), .rst(rst), .start(start), .signed_mode(smode), .a(a16), .b(b16),
    .busy(o_busy[1]), .done(o_done[1]), .a_gt_b(o_gt[1]), .a_eq_b(o_eq[1]), .b_gt_a(o_lt[1]), .cycles(o_cyc[1]));
  seq_magnitude_comparator #(.WIDTH(4), .DIGIT(1), .EARLY_EXIT(1)) u4 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(smode), .a(a16[3:0]), .b(b16[3:0]),
    .busy(o_busy[2]), .done(o_done[2]), .a_gt_b(o_gt[2]), .a_eq_b(o_eq[2]), .b_gt_a(o_lt[2]), .cycles(o_cyc[2]));

  // {gt, eq, lt, cycles} from integer values of the operands and the position of their top differing bit
  function automatic logic [5:0] ref_cmp(input logic [15:0] x, y, input logic sm, input int w, d, ee);
    int mx, vx, vy, n, p;
    logic [15:0] t;
    mx = (1 << w) - 1;
    vx = int'(x) & mx;
    vy = int'(y) & mx;
    if (sm && vx >= (1 << (w - 1))) vx -= (1 << w);
    if (sm && vy >= (1 << (w - 1))) vy -= (1 << w);
    n = w / d;
    t = 16'((x ^ y) & 16'(mx));
    if (ee != 0 && vx != vy) begin
      p = 0;
      for (int j = w - 1; j >= 0; j--) if (t[j]) begin p = j; break; end
      n = (w - 1 - p) / d + 1;
    end
    return {vx > vy, vx == vy, vx < vy, 3'(n)};
  endfunction

  int rem [3] = '{0, 0, 0};
  logic m_busy [3] = '{0, 0, 0};
  logic m_done [3] = '{0, 0, 0};
  logic [5:0] m_res [3] = '{0, 0, 0};
  logic [5:0] pend [3] = '{0, 0, 0};
  logic armed = 1'b0;

  always @(posedge clk) begin
    armed <= 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        rem[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_res[i] = '0;
      end else if (rem[i] > 0) begin
        rem[i]--;
        if (rem[i] == 0) begin m_busy[i] = 0; m_done[i] = 1; m_res[i] = pend[i]; end
      end else if (start) begin
        pend[i] = ref_cmp(a16, b16, smode, i == 2 ? 4 : 16, i == 2 ? 1 : 4, i != 1 ? 1 : 0);
        rem[i] = int'(pend[i][2:0]);
        m_busy[i] = 1; m_done[i] = 0; m_res[i] = '0;
      end else begin
        m_done[i] = 0;
      end
    end
  end

  always @(negedge clk) if (armed) for (int i = 0; i < 3; i++) begin
    n_vec++;
    if ({o_busy[i], o_done[i]} !== {m_busy[i], m_done[i]}) begin
      n_err++;
      $display("FAIL ctl[%0d] t=%0t busy/done got %b%b expected %b%b", i, $time, o_busy[i], o_done[i], m_busy[i], m_done[i]);
    end
    if (!m_busy[i] || i != 1) begin
      n_vec++;
      if ({o_gt[i], o_eq[i], o_lt[i], o_cyc[i]} !== m_res[i]) begin
        n_err++;
        $display("FAIL res[%0d] t=%0t gt/eq/lt/cyc got %b%b%b/%0d expected %b/%0d", i, $time,
                 o_gt[i], o_eq[i], o_lt[i], o_cyc[i], m_res[i][5:3], m_res[i][2:0]);
      end
    end
    if (o_done[i] === 1'b1) begin
      n_vec++;
      if ($countones({o_gt[i], o_eq[i], o_lt[i]}) != 1) begin
        n_err++;
        $display("FAIL onehot[%0d] t=%0t flags got %b expected exactly one set", i, $time, {o_gt[i], o_eq[i], o_lt[i]});
      end
    end
  end

  task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [5:0] res(input int i);
    return {o_gt[i], o_eq[i], o_lt[i], o_cyc[i]};
  endfunction

  // one comparison; returns the early-exit and constant-time results and the early-exit latency
  task automatic go(input logic [15:0] x, y, input logic sm, gl, output logic [5:0] rf, rc, output int lat);
    @(negedge clk);
    a16 = x; b16 = y; smode = sm; start = 1'b1;
    @(negedge clk);
    start = gl; a16 = 16'($urandom); b16 = 16'($urandom); smode = ~sm;
    rf = 'x; rc = 'x; lat = -1;
    for (int k = 0; k < 12; k++) begin
      if (o_done[0] && lat < 0) begin rf = res(0); lat = k; end
      if (o_done[1]) begin rc = res(1); break; end
      @(negedge clk);
      start = 1'b0;
    end
    if (lat < 0 || $isunknown(rc)) begin
      n_vec++; n_err++;
      $display("FAIL timeout: got no done within 12 cycles expected done");
    end
    @(negedge clk);
  endtask

  logic [5:0] rf, rc;
  int lat;
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    lit("reset_state", {o_busy[0], o_done[0], res(0)}, 8'h00);
    go(16'h1234, 16'h1234, 0, 0, rf, rc, lat);
    lit("eq_res", rf, {3'b010, 3'd4}); lit("eq_lat", lat, 4); lit("eq_const", rc, {3'b010, 3'd4});
    go(16'h8000, 16'h7FFF, 0, 0, rf, rc, lat);
    lit("uns_res", rf, {3'b100, 3'd1}); lit("uns_lat", lat, 1); lit("uns_const", rc, {3'b100, 3'd4});
    go(16'h8000, 16'h7FFF, 1, 0, rf, rc, lat);
    lit("sgn_res", rf, {3'b001, 3'd1}); lit("sgn_const", rc, {3'b001, 3'd4});
    go(16'h0A00, 16'h0900, 0, 1, rf, rc, lat);
    lit("glitch_res", rf, {3'b100, 3'd2}); lit("glitch_lat", lat, 2);
    go(16'hFFFF, 16'h0001, 1, 0, rf, rc, lat);
    lit("neg1_res", rf, {3'b001, 3'd1});
    // reset lands on the second RUN edge
    @(negedge clk); a16 = 16'h1234; b16 = 16'h1234; smode = 0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    lit("abort_outputs", {o_busy[0], o_done[0], res(0), o_busy[1], o_done[1], res(1)}, 16'h0000);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    go(16'h0001, 16'h0002, 0, 0, rf, rc, lat);
    lit("after_abort", rf, {3'b001, 3'd4});
    // start held through DONE re-arms immediately
    @(negedge clk); a16 = 16'h8000; b16 = 16'h7FFF; smode = 0; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    lit("b2b_done", {o_busy[0], o_done[0], res(0)}, {2'b01, 3'b100, 3'd1});
    @(negedge clk);
    lit("b2b_rearm", {o_busy[0], o_done[0], res(0)}, {2'b10, 6'h00});
    start = 1'b0;
    repeat (6) @(negedge clk);
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          go(16'(x), 16'(y), s[0], 0, rf, rc, lat);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
